// File: rtl/enc_pkg.sv
// Shared types and widths for the 8-to-3 sequential priority encoder.
// Holds the FSM state encoding and small index/vector helpers.
package enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  // Kept as plain constants so older tools and waveform decoders see fixed codes.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t EMIT = 1'b1;

  function automatic logic [VEC_W-1:0] idx2mask(input logic [IDX_W-1:0] idx);
    idx2mask = VEC_W'(1) << idx;
  endfunction

endpackage

// File: rtl/enc8to3_prio.sv
// Combinational priority find over the pending vector: index of lowest (or highest) set bit,
// plus a flag that exactly one bit remains. Zero latency, no flow control.
module enc8to3_prio
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_hot
);

  // The last matching iteration wins, so the scan direction picks the priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign one_hot = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);

endmodule

// File: rtl/enc8to3_seq.sv
// Captures an 8-bit request vector and emits the index of each set bit, one per handshake;
// 1-cycle capture-to-output latency, output held under out_ready backpressure. ENC_COUNT_EN adds cnt.
module enc8to3_seq
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] dout,
  output logic             out_last,
  output logic             zero_hit
`ifdef ENC_COUNT_EN
  ,
  output logic [3:0]       cnt
`endif
);

  state_t           state;
  logic [VEC_W-1:0] pending;
  logic [IDX_W-1:0] idx;
  logic             one_hot;
  logic             accept;
  logic             emit_hs;

  enc8to3_prio #(
    .MSB_FIRST(MSB_FIRST)
  ) u_prio (
    .vec    (pending),
    .idx    (idx),
    .one_hot(one_hot)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  // pending is zero outside EMIT, so dout reads 0 when idle.
  assign dout      = idx;
  assign out_last  = (state == EMIT) && one_hot;
  assign accept    = in_valid && in_ready;
  assign emit_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      zero_hit <= 1'b0;
    end else begin
      zero_hit <= accept && (din == '0);
      case (state)
        IDLE: begin
          if (accept && (din != '0)) begin
            pending <= din;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (emit_hs) begin
            pending <= pending & ~idx2mask(idx);
            if (out_last) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

`ifdef ENC_COUNT_EN
  logic [3:0] din_pop;

  always_comb begin
    din_pop = '0;
    for (int i = 0; i < VEC_W; i++) begin
      din_pop = din_pop + {3'b000, din[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      if (accept && (din != '0)) cnt <= din_pop;
    end else if (emit_hs && out_last) begin
      cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Scoreboarded bench: two DUTs (lowest-first and highest-first) share stimulus;
// expected index streams are built from the captured vector and popped on each output handshake.
module tb_enc8to3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] din;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, zero_hit0;
  logic [2:0] dout0;
  logic       in_ready1, out_valid1, out_last1, zero_hit1;
  logic [2:0] dout1;
`ifdef ENC_COUNT_EN
  logic [3:0] cnt0, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  int q0[$];
  int q1[$];
  int exp_pop = 0;
  bit zh_exp  = 1'b0;
  bit started = 1'b0;
  bit hold_v  = 1'b0;
  int hold_d0, hold_d1;

  enc8to3_seq #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
    .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .out_last(out_last0),
    .zero_hit(zero_hit0)
`ifdef ENC_COUNT_EN
    , .cnt(cnt0)
`endif
  );

  enc8to3_seq #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .din(din),
    .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1), .out_last(out_last1),
    .zero_hit(zero_hit1)
`ifdef ENC_COUNT_EN
    , .cnt(cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, compare against the scoreboard, then record new captures.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      exp_pop = 0;
      hold_v  = 1'b0;
      if (started) begin
        chk("zero_hit0_rst", zero_hit0, zh_exp);
      end
      zh_exp = 1'b0;
    end else if (started) begin
      chk("zero_hit0", zero_hit0, zh_exp);
      chk("zero_hit1", zero_hit1, zh_exp);
      chk("out_valid0", out_valid0, q0.size() != 0);
      chk("out_valid1", out_valid1, q1.size() != 0);
      chk("in_ready0", in_ready0, q0.size() == 0);
      chk("in_ready1", in_ready1, q1.size() == 0);
`ifdef ENC_COUNT_EN
      chk("cnt0", cnt0, (q0.size() != 0) ? exp_pop : 0);
      chk("cnt1", cnt1, (q1.size() != 0) ? exp_pop : 0);
`endif
      if (hold_v) begin
        chk("hold_valid", out_valid0, 1);
        chk("hold_dout0", dout0, hold_d0);
        chk("hold_dout1", dout1, hold_d1);
      end
      hold_v = out_valid0 && !out_ready;
      hold_d0 = dout0;
      hold_d1 = dout1;
      if (out_valid0 && q0.size() != 0) begin
        chk("dout0", dout0, q0[0]);
        chk("last0", out_last0, q0.size() == 1);
        if (out_ready) void'(q0.pop_front());
      end
      if (out_valid1 && q1.size() != 0) begin
        chk("dout1", dout1, q1[0]);
        chk("last1", out_last1, q1.size() == 1);
        if (out_ready) void'(q1.pop_front());
      end
      zh_exp = in_valid && in_ready0 && (din == 8'h00);
      if (in_valid && in_ready0 && din != 8'h00) begin
        exp_pop = 0;
        for (int i = 0; i < 8; i++) begin
          if (din[i]) begin
            q0.push_back(i);
            q1.push_front(i);
            exp_pop++;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    bit ok;
    in_valid = 1'b1;
    din      = d;
    for (int n = 0; n < 100; n++) begin
      ok = in_ready0;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready0) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_idle_state(input string name);
    chk({name, "_vld"}, out_valid0, 0);
    chk({name, "_rdy"}, in_ready0, 1);
    chk({name, "_dout"}, dout0, 0);
    chk({name, "_last"}, out_last1, 0);
  endtask

  int n;
  logic [7:0] v;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    rst_n   = 1'b1;
    chk_idle_state("reset");
    chk("reset_zh", zero_hit0, 0);

    // Sustained drain of three bits.
    out_ready = 1'b1;
    send(8'b0010_1001);
    wait_idle(n);
    chk("drain3_cycles", n, 3);

    // Backpressure on a two-bit vector.
    out_ready = 1'b0;
    send(8'h90);
    for (int i = 0; i < 3; i++) begin
      chk("bp_dout0", dout0, 4);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_idle(n);
    chk("bp_drain_cycles", n, 2);

    // Zero vector: single pulse, nothing emitted.
    send(8'h00);
    chk("zero_pulse", zero_hit0, 1);
    chk("zero_vld", out_valid0, 0);
    chk("zero_rdy", in_ready0, 1);
    @(posedge clk);
    #1;
    chk("zero_pulse_end", zero_hit0, 0);

    send(8'hFF);
`ifdef ENC_COUNT_EN
    chk("ff_cnt1", cnt1, 8);
`endif
    wait_idle(n);
    chk("ff_cycles", n, 8);

    for (int b = 0; b < 8; b++) begin
      v = 8'h01 << b;
      send(v);
      chk("single_dout", dout0, b);
      chk("single_last", out_last0, 1);
      wait_idle(n);
    end

    // Reset in the middle of an emission.
    out_ready = 1'b0;
    send(8'hA5);
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b1; din = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_state("midrst");
    out_ready = 1'b1;

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      din       = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(n);
    @(posedge clk);
    #1;
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
